// File: rtl/uart_rx_if.sv
// Receive-side bundle of the UART receiver: serial line in, byte/status out.
interface uart_rx_if;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Active;
    logic       o_Rx_Frame_Err;

    // Receiver side: consumes the line, produces byte and status.
    modport master (
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Byte,
        output o_Rx_Active,
        output o_Rx_Frame_Err
    );

    // Line driver / byte consumer side.
    modport slave (
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Byte,
        input  o_Rx_Active,
        input  o_Rx_Frame_Err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. The line is synchronized, the start bit is
// re-checked at its centre to reject glitches, and each data/stop bit is
// sampled one bit period after the previous sample. A low stop bit raises a
// one-cycle frame error and the receiver then waits for the line to go high
// before looking for another start edge.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic     i_Clock,
    input  logic     i_Reset,
    uart_rx_if.master rx
);

    // Start bit is checked half a bit in; data/stop one full bit apart.
    localparam logic [7:0] HALF_CNT = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] BIT_END  = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_CLEANUP   = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       dv_q, dv_d;
    logic       err_q, err_d;
    logic       active_q, active_d;
    logic       rx_meta_q;
    logic       rx_s_q;
    logic       rx_s;

    assign rx_s = rx_s_q;

    // Next-state and registered-output logic for the frame FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        err_d     = 1'b0;
        active_d  = active_q;

        case (state_q)
            S_IDLE: begin
                cnt_d     = 8'd0;
                bit_idx_d = 3'd0;
                if (!rx_s) begin
                    state_d  = S_START;
                    active_d = 1'b1;
                end
            end

            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = 8'd0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                    end else begin
                        // Line came back high before mid start bit: a glitch.
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d            = 8'd0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d = 8'd0;
                    if (rx_s) begin
                        state_d = S_CLEANUP;
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                    end else begin
                        // Bad stop bit: keep the old byte, hold off until idle.
                        state_d = S_WAIT_HIGH;
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_CLEANUP: begin
                cnt_d    = 8'd0;
                state_d  = S_IDLE;
                active_d = 1'b0;
            end

            S_WAIT_HIGH: begin
                cnt_d = 8'd0;
                if (rx_s) begin
                    state_d  = S_IDLE;
                    active_d = 1'b0;
                end
            end

            default: begin
                state_d   = S_IDLE;
                cnt_d     = 8'd0;
                bit_idx_d = 3'd0;
                active_d  = 1'b0;
            end
        endcase
    end

    // Line synchronizer and all FSM state; synchronizer resets to idle-high.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            rx_meta_q <= rx.i_Rx_Serial;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
            active_q  <= active_d;
        end
    end

    assign rx.o_Rx_DV        = dv_q;
    assign rx.o_Rx_Byte      = byte_q;
    assign rx.o_Rx_Active    = active_q;
    assign rx.o_Rx_Frame_Err = err_q;

    // A frame ends either good or bad, never both.
    a_dv_err_excl : assert property (@(posedge i_Clock) disable iff (!i_Reset)
        !(dv_q && err_q));

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: builds a line/reset waveform (directed cases followed by
// randomized frames), derives the expected per-cycle outputs from the frame
// timing rules, then replays the waveform and compares every cycle.
module tb_uart_rx;
    localparam int CPB  = 87;
    localparam int HALF = (CPB - 1) / 2;
    localparam int NMAX = 60000;

    logic i_Clock = 1'b0;
    logic i_Reset = 1'b0;

    uart_rx_if rx_if ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .rx      (rx_if)
    );

    always #5 i_Clock = ~i_Clock;

    // Stimulus: line_a[p] / rst_a[p] are the values present at rising edge p.
    bit         line_a  [NMAX];
    bit         rst_a   [NMAX];
    // Expected outputs observed just after rising edge p.
    bit         exp_act [NMAX];
    bit         exp_dv  [NMAX];
    bit         exp_err [NMAX];
    bit         ld      [NMAX];
    logic [7:0] ld_val  [NMAX];
    logic [7:0] exp_byte[NMAX];

    int wp;
    int n_cyc;
    int d_end;
    int checks;
    int errors;

    logic [7:0] dut_dv_bytes[$];
    int         dut_dv_cyc[$];
    int         dut_err_cyc[$];
    logic [7:0] mdl_dv_bytes[$];
    int         mdl_err_cyc[$];

    task automatic put(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            line_a[wp] = v;
            rst_a[wp]  = 1'b0;
            wp++;
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit; bp cycles per bit.
    task automatic put_frame(input logic [7:0] b, input int bp, input bit stop);
        put(1'b0, bp);
        for (int k = 0; k < 8; k++) put(b[k], bp);
        put(stop, bp);
    endtask

    task automatic put_reset(input int at, input int n);
        for (int i = 0; i < n; i++) rst_a[at + i] = 1'b1;
    endtask

    // Synchronized line as the receiver sees it during cycle p.
    function automatic bit rxs(input int p);
        if (p < 1) return 1'b1;
        if (rst_a[p] || rst_a[p - 1]) return 1'b1;
        return line_a[p - 1];
    endfunction

    function automatic int first_rst(input int a, input int b);
        for (int c = a; c <= b; c++) if (rst_a[c]) return c;
        return -1;
    endfunction

    // Walk the waveform frame by frame using the bit-timing rules:
    // start edge e, start check at e+1+HALF, then one sample every CPB.
    task automatic build_model();
        int p, e, s0, s9, w, fin, r, last;
        logic [7:0] v;
        bit good, glitch;
        p = 1;
        while (p < n_cyc) begin
            if (rst_a[p] || rxs(p)) begin
                p++;
                continue;
            end
            e  = p;
            s0 = e + 1 + HALF;
            s9 = s0 + 9 * CPB;
            if (s9 + 2 >= n_cyc) break;
            glitch = rxs(s0);
            good   = 1'b0;
            v      = 8'h00;
            if (glitch) begin
                fin = s0;
            end else begin
                for (int k = 0; k < 8; k++) v[k] = rxs(s0 + (k + 1) * CPB);
                good = rxs(s9);
                if (good) begin
                    fin = s9 + 1;
                end else begin
                    w = s9 + 1;
                    while (w < n_cyc - 1 && !rxs(w)) w++;
                    fin = w;
                end
            end
            r    = first_rst(e + 1, fin);
            last = (r >= 0) ? r - 1 : fin;
            for (int c = e + 1; c <= last; c++) exp_act[c] = 1'b1;
            if (!glitch && (r < 0 || s9 + 1 < r)) begin
                if (good) begin
                    exp_dv[s9 + 1] = 1'b1;
                    ld[s9 + 1]     = 1'b1;
                    ld_val[s9 + 1] = v;
                    mdl_dv_bytes.push_back(v);
                end else begin
                    exp_err[s9 + 1] = 1'b1;
                    mdl_err_cyc.push_back(s9 + 1);
                end
            end
            p = (r >= 0) ? r : fin + 1;
        end
        begin
            logic [7:0] cur;
            cur = 8'h00;
            for (int c = 0; c < n_cyc; c++) begin
                if (rst_a[c])  cur = 8'h00;
                else if (ld[c]) cur = ld_val[c];
                exp_byte[c] = cur;
            end
        end
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b want %b", nm, got, want);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic chk_byte(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        int bp, f, glen, n_err_dir, n_dv_dir;
        logic [7:0] b;
        bit stop;
        logic [7:0] lit [6];

        checks = 0;
        errors = 0;
        rx_if.i_Rx_Serial = 1'b1;
        i_Reset = 1'b0;
        wp = 0;

        // Directed section.
        put(1'b1, 4);
        put_reset(0, 4);
        put(1'b1, 20);
        put_frame(8'h3C, 87, 1'b1); put(1'b1, 50);
        put_frame(8'h55, 87, 1'b1); put_frame(8'hAA, 87, 1'b1); put(1'b1, 50);
        put(1'b0, 20); put(1'b1, 200);
        put_frame(8'hA5, 87, 1'b0); put(1'b0, 300); put(1'b1, 100);
        f = wp;
        put_frame(8'hFF, 87, 1'b1);
        put_reset(f + 5 * 87 + 10, 3);
        put(1'b1, 100);
        put_frame(8'h12, 87, 1'b1); put(1'b1, 50);
        put_frame(8'h81, 85, 1'b1); put(1'b1, 50);
        put_frame(8'h81, 89, 1'b1); put(1'b1, 100);
        d_end = wp;

        // Randomized section: byte, sender rate, bad stops, glitches, resets.
        for (int i = 0; i < 25; i++) begin
            bp   = int'($urandom_range(89, 85));
            b    = 8'($urandom);
            stop = ($urandom_range(5, 0) != 0);
            if ($urandom_range(3, 0) == 0) begin
                glen = int'($urandom_range(30, 1));
                put(1'b0, glen);
                put(1'b1, int'($urandom_range(120, 50)));
            end
            f = wp;
            put_frame(b, bp, stop);
            if (!stop) put(1'b0, int'($urandom_range(200, 0)));
            if ($urandom_range(7, 0) == 0)
                put_reset(f + int'($urandom_range(800, 1)), int'($urandom_range(3, 1)));
            put(1'b1, int'($urandom_range(40, 0)));
        end
        put(1'b1, 400);
        n_cyc = wp;

        build_model();

        // Replay: drive on the falling edge, compare 1 time unit after rising.
        @(negedge i_Clock);
        for (int p = 1; p < n_cyc; p++) begin
            rx_if.i_Rx_Serial = line_a[p];
            i_Reset = !rst_a[p];
            if (rst_a[p] && !rst_a[p - 1]) begin
                #1;
                chk_bit("reset_now_dv", rx_if.o_Rx_DV, 1'b0);
                chk_bit("reset_now_err", rx_if.o_Rx_Frame_Err, 1'b0);
                chk_bit("reset_now_active", rx_if.o_Rx_Active, 1'b0);
                chk_byte("reset_now_byte", rx_if.o_Rx_Byte, 8'h00);
            end
            @(posedge i_Clock);
            #1;
            if (rx_if.o_Rx_DV) begin
                dut_dv_bytes.push_back(rx_if.o_Rx_Byte);
                dut_dv_cyc.push_back(p);
            end
            if (rx_if.o_Rx_Frame_Err) dut_err_cyc.push_back(p);
            checks++;
            if ({rx_if.o_Rx_DV, rx_if.o_Rx_Frame_Err, rx_if.o_Rx_Active, rx_if.o_Rx_Byte} !==
                {exp_dv[p], exp_err[p], exp_act[p], exp_byte[p]}) begin
                errors++;
                $display("FAIL cycle %0d dv/err/active/byte got %b/%b/%b/%h want %b/%b/%b/%h",
                         p, rx_if.o_Rx_DV, rx_if.o_Rx_Frame_Err, rx_if.o_Rx_Active,
                         rx_if.o_Rx_Byte, exp_dv[p], exp_err[p], exp_act[p], exp_byte[p]);
            end
            @(negedge i_Clock);
        end

        // Hand-derived expectations for the directed section.
        lit = '{8'h3C, 8'h55, 8'hAA, 8'h12, 8'h81, 8'h81};
        n_dv_dir = 0;
        foreach (dut_dv_cyc[i]) if (dut_dv_cyc[i] < d_end) n_dv_dir++;
        chk_int("directed_dv_count", n_dv_dir, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < dut_dv_bytes.size()) chk_byte($sformatf("dut_byte%0d", i), dut_dv_bytes[i], lit[i]);
            else chk_int($sformatf("dut_byte%0d_present", i), dut_dv_bytes.size(), i + 1);
            if (i < mdl_dv_bytes.size()) chk_byte($sformatf("model_byte%0d", i), mdl_dv_bytes[i], lit[i]);
            else chk_int($sformatf("model_byte%0d_present", i), mdl_dv_bytes.size(), i + 1);
        end
        if (dut_dv_cyc.size() >= 3) chk_int("b2b_spacing", dut_dv_cyc[2] - dut_dv_cyc[1], 870);
        else chk_int("b2b_dv_present", dut_dv_cyc.size(), 3);
        n_err_dir = 0;
        foreach (dut_err_cyc[i]) if (dut_err_cyc[i] < d_end) n_err_dir++;
        chk_int("directed_err_count", n_err_dir, 1);
        n_err_dir = 0;
        foreach (mdl_err_cyc[i]) if (mdl_err_cyc[i] < d_end) n_err_dir++;
        chk_int("model_err_count", n_err_dir, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
